// File: rtl/fp_round_stage.sv
// fp_round_stage: two-stage IEEE-754 single-precision rounding pipeline.
// Stage A captures the operand and decides whether to round up.
// Stage B applies the increment, resolves overflow/specials and registers the result.
module fp_round_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  clear,
  input  logic        valid_i,
  input  logic        sign_i,
  input  logic [7:0]  exp_i,
  input  logic [46:0] mant_i,
  input  logic        is_nan_i,
  input  logic        is_inf_i,
  input  logic        is_zero_i,
  input  logic        nv_i,
  input  logic [2:0]  rm_i,
  input  logic [4:0]  rd_i,
  input  logic        fp_reg_write_i,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic [4:0]  fflags_o,
  output logic [4:0]  rd_o,
  output logic        fp_reg_write_o,
  output logic [9:0]  uu_rd,
  output logic [1:0]  uu_fp_reg_write
);

  // Stage A registers
  logic        r_a_valid;
  logic        r_a_sign;
  logic [7:0]  r_a_exp;
  logic [22:0] r_a_frac;
  logic        r_a_inc;
  logic        r_a_inexact;
  logic        r_a_nan;
  logic        r_a_inf;
  logic        r_a_zero;
  logic        r_a_nv;
  logic [2:0]  r_a_rm;
  logic [4:0]  r_a_rd;
  logic        r_a_fpw;

  // Stage B registers
  logic        r_b_valid;
  logic [31:0] r_b_result;
  logic [4:0]  r_b_fflags;
  logic [4:0]  r_b_rd;
  logic        r_b_fpw;

  logic        w_guard;
  logic        w_round;
  logic        w_sticky;
  logic        w_lsb;
  logic        w_grs;
  logic        w_inc;
  logic [30:0] w_sum;
  logic [7:0]  w_rexp;
  logic        w_ovf;
  logic        w_to_inf;
  logic [31:0] w_result;
  logic [4:0]  w_fflags;

  // Round-up decision from guard/round/sticky, LSB and rounding mode
  always_comb begin
    w_guard  = mant_i[23];
    w_round  = mant_i[22];
    w_sticky = |mant_i[21:0];
    w_lsb    = mant_i[24];
    w_grs    = w_guard | w_round | w_sticky;
    w_inc    = 1'b0;
    case (rm_i)
      3'b001:  w_inc = 1'b0;
      3'b010:  w_inc = sign_i & w_grs;
      3'b011:  w_inc = ~sign_i & w_grs;
      3'b100:  w_inc = w_guard;
      default: w_inc = w_guard & (w_round | w_sticky | w_lsb);
    endcase
  end

  // Stage A capture; flush beats advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear[1]) begin
      r_a_valid   <= 1'b0;
      r_a_sign    <= 1'b0;
      r_a_exp     <= '0;
      r_a_frac    <= '0;
      r_a_inc     <= 1'b0;
      r_a_inexact <= 1'b0;
      r_a_nan     <= 1'b0;
      r_a_inf     <= 1'b0;
      r_a_zero    <= 1'b0;
      r_a_nv      <= 1'b0;
      r_a_rm      <= '0;
      r_a_rd      <= '0;
      r_a_fpw     <= 1'b0;
    end else if (en) begin
      r_a_valid   <= valid_i;
      r_a_sign    <= sign_i;
      r_a_exp     <= exp_i;
      r_a_frac    <= mant_i[46:24];
      r_a_inc     <= w_inc;
      r_a_inexact <= w_grs;
      r_a_nan     <= is_nan_i;
      r_a_inf     <= is_inf_i;
      r_a_zero    <= is_zero_i;
      r_a_nv      <= nv_i;
      r_a_rm      <= rm_i;
      r_a_rd      <= rd_i;
      r_a_fpw     <= fp_reg_write_i;
    end
  end

  // Apply increment across {exp,frac} so a fraction carry bumps the exponent
  always_comb begin
    w_sum    = {r_a_exp, r_a_frac} + 31'(r_a_inc);
    w_rexp   = w_sum[30:23];
    w_ovf    = (r_a_exp == 8'hFF) || (w_rexp == 8'hFF);
    w_to_inf = 1'b1;
    case (r_a_rm)
      3'b001:  w_to_inf = 1'b0;
      3'b010:  w_to_inf = r_a_sign;
      3'b011:  w_to_inf = ~r_a_sign;
      default: w_to_inf = 1'b1;
    endcase
  end

  // Final result and flags with NaN > inf > zero > overflow > normal priority
  always_comb begin
    w_result = '0;
    w_fflags = '0;
    if (r_a_nan) begin
      w_result = 32'h7FC00000;
      w_fflags = {r_a_nv, 4'b0000};
    end else if (r_a_inf) begin
      w_result = {r_a_sign, 31'h7F800000};
    end else if (r_a_zero) begin
      w_result = {r_a_sign, 31'h0};
    end else if (w_ovf) begin
      w_result = {r_a_sign, (w_to_inf ? 31'h7F800000 : 31'h7F7FFFFF)};
      w_fflags = 5'b00101;
    end else begin
      w_result = {r_a_sign, w_sum};
      w_fflags = {3'b000, r_a_inexact & (w_rexp == 8'h00), r_a_inexact};
    end
  end

  // Stage B capture; flush beats advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear[0]) begin
      r_b_valid  <= 1'b0;
      r_b_result <= '0;
      r_b_fflags <= '0;
      r_b_rd     <= '0;
      r_b_fpw    <= 1'b0;
    end else if (en) begin
      r_b_valid  <= r_a_valid;
      r_b_result <= w_result;
      r_b_fflags <= w_fflags;
      r_b_rd     <= r_a_rd;
      r_b_fpw    <= r_a_fpw;
    end
  end

  assign valid_o         = r_b_valid;
  assign result_o        = r_b_result;
  assign fflags_o        = r_b_fflags;
  assign rd_o            = r_b_rd;
  assign fp_reg_write_o  = r_b_fpw;
  assign uu_rd           = {r_a_rd, r_b_rd};
  assign uu_fp_reg_write = {r_a_fpw, r_b_fpw};

endmodule

// File: tb/tb_fp_round_stage.sv
// Bench for fp_round_stage: an answer-level pipeline model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_fp_round_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  clear = 2'b00;
  logic        valid_i = 1'b0;
  logic        sign_i = 1'b0;
  logic [7:0]  exp_i = '0;
  logic [46:0] mant_i = '0;
  logic        is_nan_i = 1'b0;
  logic        is_inf_i = 1'b0;
  logic        is_zero_i = 1'b0;
  logic        nv_i = 1'b0;
  logic [2:0]  rm_i = '0;
  logic [4:0]  rd_i = '0;
  logic        fp_reg_write_i = 1'b0;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;
  logic [4:0]  rd_o;
  logic        fp_reg_write_o;
  logic [9:0]  uu_rd;
  logic [1:0]  uu_fp_reg_write;

  int total = 0;
  int bad = 0;

  fp_round_stage dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .valid_i(valid_i),
    .sign_i(sign_i), .exp_i(exp_i), .mant_i(mant_i), .is_nan_i(is_nan_i),
    .is_inf_i(is_inf_i), .is_zero_i(is_zero_i), .nv_i(nv_i), .rm_i(rm_i),
    .rd_i(rd_i), .fp_reg_write_i(fp_reg_write_i), .valid_o(valid_o),
    .result_o(result_o), .fflags_o(fflags_o), .rd_o(rd_o),
    .fp_reg_write_o(fp_reg_write_o), .uu_rd(uu_rd), .uu_fp_reg_write(uu_fp_reg_write)
  );

  always #5 clk = ~clk;

  // Expected {fflags,result} from the IEEE rounding rules in plain arithmetic.
  function automatic logic [36:0] fp_expect(input logic s, input logic [7:0] e,
      input logic [46:0] m, input logic nan, input logic inf, input logic zero,
      input logic nv, input logic [2:0] rm);
    longint mag;
    longint newexp;
    int     mode;
    bit     g, rest, lsb, inexact, up, ovf, toinf;
    logic [31:0] res;
    logic [4:0]  fl;
    if (nan)  return {nv, 4'b0000, 32'h7FC00000};
    if (inf)  return {5'b00000, s, 31'h7F800000};
    if (zero) return {5'b00000, s, 31'h0};
    g       = m[23];
    rest    = (m[22:0] != 23'h0);
    lsb     = m[24];
    inexact = g || rest;
    mode    = (rm > 3'd4) ? 0 : int'(rm);
    case (mode)
      0: up = g && (rest || lsb);
      1: up = 1'b0;
      2: up = s && inexact;
      3: up = !s && inexact;
      default: up = g;
    endcase
    mag    = longint'({e, m[46:24]}) + (up ? 64'd1 : 64'd0);
    newexp = mag >> 23;
    ovf    = (e == 8'hFF) || (newexp >= 255);
    if (ovf) begin
      toinf = (mode == 0) || (mode == 4) || (mode == 2 && s) || (mode == 3 && !s);
      res   = {s, (toinf ? 31'h7F800000 : 31'h7F7FFFFF)};
      fl    = 5'b00101;
    end else begin
      res = {s, mag[30:0]};
      fl  = {3'b000, inexact && (newexp == 0), inexact};
    end
    return {fl, res};
  endfunction

  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic        w;
    logic [31:0] res;
    logic [4:0]  fl;
  } st_t;

  st_t mA = '0;
  st_t mB = '0;

  // Reference pipeline holding final answers per stage
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mA <= '0;
      mB <= '0;
    end else begin
      logic [36:0] x;
      x = fp_expect(sign_i, exp_i, mant_i, is_nan_i, is_inf_i, is_zero_i, nv_i, rm_i);
      if (clear[1])  mA <= '0;
      else if (en)   mA <= '{v: valid_i, rd: rd_i, w: fp_reg_write_i, res: x[31:0], fl: x[36:32]};
      if (clear[0])  mB <= '0;
      else if (en)   mB <= mA;
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the reference pipeline
  always @(negedge clk) begin
    chk("cyc_valid", 32'(valid_o), 32'(mB.v));
    chk("cyc_result", result_o, mB.res);
    chk("cyc_fflags", 32'(fflags_o), 32'(mB.fl));
    chk("cyc_rd", 32'(rd_o), 32'(mB.rd));
    chk("cyc_fpw", 32'(fp_reg_write_o), 32'(mB.w));
    chk("cyc_uu_rd", 32'(uu_rd), 32'({mA.rd, mB.rd}));
    chk("cyc_uu_fpw", 32'(uu_fp_reg_write), 32'({mA.w, mB.w}));
  end

  function automatic logic [46:0] mk(input logic [22:0] f, input logic g,
                                     input logic r, input logic [21:0] s);
    return {f, g, r, s};
  endfunction

  task automatic drive(input logic v, input logic s, input logic [7:0] e,
      input logic [46:0] m, input logic nan, input logic inf, input logic zero,
      input logic nv, input logic [2:0] rm, input logic [4:0] rd);
    valid_i = v; sign_i = s; exp_i = e; mant_i = m; is_nan_i = nan;
    is_inf_i = inf; is_zero_i = zero; nv_i = nv; rm_i = rm; rd_i = rd;
    fp_reg_write_i = v;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
  endtask

  // One operand through the pipe; result checked after the second advancing edge
  task automatic vec(input string n, input logic s, input logic [7:0] e,
      input logic [46:0] m, input logic nan, input logic inf, input logic zero,
      input logic nv, input logic [2:0] rm, input logic [4:0] rd,
      input logic [31:0] xres, input logic [4:0] xfl);
    @(negedge clk);
    en = 1'b1; clear = 2'b00;
    drive(1'b1, s, e, m, nan, inf, zero, nv, rm, rd);
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    chk({n, "_valid"}, 32'(valid_o), 32'd1);
    chk({n, "_result"}, result_o, xres);
    chk({n, "_fflags"}, 32'(fflags_o), 32'(xfl));
    chk({n, "_rd"}, 32'(rd_o), 32'(rd));
    chk({n, "_model"}, mB.res, xres);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_fflags", 32'(fflags_o), 32'd0);
    chk("rst_uu", 32'({uu_rd, uu_fp_reg_write}), 32'd0);
    rst_n = 1'b1;

    vec("exact",     1'b0, 8'h7F, mk(23'h400000, 1'b0, 1'b0, 22'h0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd1, 32'h3FC00000, 5'h00);
    vec("tie_odd",   1'b0, 8'h80, mk(23'h000001, 1'b1, 1'b0, 22'h0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd2, 32'h40000002, 5'h01);
    vec("tie_even",  1'b0, 8'h80, mk(23'h000000, 1'b1, 1'b0, 22'h0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd3, 32'h40000000, 5'h01);
    vec("carry",     1'b0, 8'h7E, mk(23'h7FFFFF, 1'b1, 1'b0, 22'h0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd4, 32'h3F800000, 5'h01);
    vec("ovf_rne",   1'b0, 8'hFE, mk(23'h7FFFFF, 1'b1, 1'b0, 22'h0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd5, 32'h7F800000, 5'h05);
    vec("ovf_rtz",   1'b0, 8'hFF, mk(23'h000000, 1'b0, 1'b0, 22'h0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 5'd6, 32'h7F7FFFFF, 5'h05);
    vec("neg_rup",   1'b1, 8'hFE, mk(23'h7FFFFF, 1'b1, 1'b0, 22'h0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 5'd7, 32'hFF7FFFFF, 5'h01);
    vec("ovf_rdn_n", 1'b1, 8'hFF, mk(23'h000000, 1'b0, 1'b0, 22'h0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 5'd8, 32'hFF800000, 5'h05);
    vec("nan",       1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 5'd9, 32'h7FC00000, 5'h10);
    vec("inf_neg",   1'b1, 8'h00, '0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd10, 32'hFF800000, 5'h00);
    vec("zero_neg",  1'b1, 8'h00, '0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 5'd11, 32'h80000000, 5'h00);
    vec("sub_norm",  1'b0, 8'h00, mk(23'h7FFFFF, 1'b1, 1'b0, 22'h0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd12, 32'h00800000, 5'h01);
    vec("sub_tiny",  1'b0, 8'h00, mk(23'h000002, 1'b1, 1'b0, 22'h0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd13, 32'h00000002, 5'h03);
    vec("rdn_stk",   1'b1, 8'h80, mk(23'h000000, 1'b0, 1'b0, 22'h1), 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 5'd14, 32'hC0000001, 5'h01);
    vec("rmm_tie",   1'b0, 8'h80, mk(23'h000000, 1'b1, 1'b0, 22'h0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 5'd15, 32'h40000001, 5'h01);
    vec("rm7_rne",   1'b0, 8'h80, mk(23'h000001, 1'b1, 1'b0, 22'h0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 5'd16, 32'h40000002, 5'h01);
    vec("nan_prio",  1'b0, 8'hFF, '0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 5'd17, 32'h7FC00000, 5'h00);

    // Stall: stage B holds rd 7, stage A holds rd 9
    @(negedge clk);
    en = 1'b1;
    drive(1'b1, 1'b0, 8'h7F, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd7);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h80, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd9);
    @(negedge clk);
    en = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(valid_o), 32'd1);
      chk("stall_result", result_o, 32'h3F800000);
      chk("stall_uu_rd", 32'(uu_rd), 32'({5'd9, 5'd7}));
      chk("stall_uu_fpw", 32'(uu_fp_reg_write), 32'd3);
    end

    // Flush stage B only while stalled
    @(negedge clk);
    clear = 2'b01;
    @(posedge clk); #1;
    chk("clrB_valid", 32'(valid_o), 32'd0);
    chk("clrB_rd", 32'(rd_o), 32'd0);
    chk("clrB_uu_rd", 32'(uu_rd), 32'({5'd9, 5'd0}));
    chk("clrB_uu_fpw", 32'(uu_fp_reg_write), 32'd2);
    @(negedge clk);
    clear = 2'b00; en = 1'b1;
    @(posedge clk); #1;
    chk("afterB_valid", 32'(valid_o), 32'd1);
    chk("afterB_rd", 32'(rd_o), 32'd9);
    chk("afterB_result", result_o, 32'h40000000);

    // Flush both stages at once, over an enabled advance
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h81, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd20);
    @(negedge clk);
    idle();
    clear = 2'b11;
    @(posedge clk); #1;
    chk("clrAB_valid", 32'(valid_o), 32'd0);
    chk("clrAB_uu_rd", 32'(uu_rd), 32'd0);
    chk("clrAB_result", result_o, 32'd0);
    @(negedge clk);
    clear = 2'b00;

    // Reset mid-flight discards the operand in stage A
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h7F, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd3);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst_uu_rd", 32'(uu_rd), 32'd0);
    chk("midrst_valid", 32'(valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_valid1", 32'(valid_o), 32'd0);
    @(posedge clk); #1;
    chk("postrst_valid2", 32'(valid_o), 32'd0);
    vec("postrst", 1'b0, 8'h7F, mk(23'h400000, 1'b0, 1'b0, 22'h0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd21, 32'h3FC00000, 5'h00);

    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_round_stage.md
FP_ROUND_STAGE -- requirements
Module: fp_round_stage

Interface
REQ-001 SHALL have these ports, with clock and reset first:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  pipeline advance enable
- clear  in  2  per-stage flush; clear[1] flushes stage A, clear[0] flushes stage B
- valid_i  in  1  operand valid
- sign_i  in  1  result sign
- exp_i  in  8  normalized biased exponent; 0 means subnormal; 0xFF means pre-round overflow
- mant_i  in  47  [46:24] fraction, [23] guard G, [22] round R, [21:0] sticky source
- is_nan_i, is_inf_i, is_zero_i  in  1 each  special-case flags
- nv_i  in  1  invalid-operation flag from upstream
- rm_i  in  3  rounding mode
- rd_i  in  5  destination register
- fp_reg_write_i  in  1  FP write enable
- valid_o  out  1  result valid
- result_o  out  32  IEEE-754 single result
- fflags_o  out  5  {NV,DZ,OF,UF,NX}
- rd_o  out  5  destination register
- fp_reg_write_o  out  1  FP write enable
- uu_rd  out  2x5  {stage A rd, stage B rd}, for hazard and clear logic
- uu_fp_reg_write  out  2  {stage A, stage B} FP write enables

Function
REQ-002 SHALL be a 2-stage pipeline: stage A registers inputs and the rounding decision; stage B registers the final result.
REQ-003 Latency SHALL be 2 en-cycles: inputs sampled on edge N with en=1 appear on outputs after edge N+1 with en=1.
REQ-004 en=0 SHALL hold both stages unchanged; there is no bubble insertion.
REQ-005 clear[k] SHALL zero every register of its stage, valid included; clear SHALL take priority over en.
REQ-006 Simultaneous clear[1] and clear[0] SHALL zero both stages in the same cycle.
REQ-007 Stage A SHALL compute S = |mant_i[21:0], L = mant_i[24], and inc by rm_i:
- 000 RNE: G&(R|S|L)
- 001 RTZ: 0
- 010 RDN: sign&(G|R|S)
- 011 RUP: ~sign&(G|R|S)
- 100 RMM: G
- 101-111: treated as RNE
REQ-008 Stage B SHALL form the 31-bit sum {exp,frac}+inc, so a fraction carry increments the exponent and a subnormal may round to normal.
REQ-009 Overflow SHALL be declared when exp_i==0xFF (non-special) or when the rounded exponent equals 0xFF.
REQ-010 On overflow the result SHALL be ±infinity for RNE/RMM, RDN with sign=1, or RUP with sign=0; otherwise it SHALL be ±0x7F7FFFFF (max finite). OF and NX SHALL be set.
REQ-011 NX SHALL equal G|R|S for non-special operands, or 1 on overflow.
REQ-012 UF SHALL equal NX & (rounded exponent==0), i.e. tininess detected after rounding.
REQ-013 DZ SHALL always be 0.
REQ-014 Special-case priority SHALL be NaN > inf > zero > normal/overflow:
- NaN: result 0x7FC00000, fflags {nv_i,4'b0}
- inf: result {sign,0x7F800000[30:0]}, flags 0
- zero: result {sign,31'b0}, flags 0
REQ-015 rd, fp_reg_write and valid SHALL travel with their data through both stages unchanged.
REQ-016 uu_rd and uu_fp_reg_write SHALL reflect the current stage A and stage B register contents combinationally.

Reset
REQ-017 rst_n low SHALL asynchronously zero every register. Consequently valid_o=0, result_o=0, fflags_o=0, rd_o=0, fp_reg_write_o=0 and uu_*=0.
REQ-018 Reset asserted mid-operation SHALL discard in-flight data; the first valid_o after release SHALL come from post-reset inputs.

Verification
REQ-019 Benches SHALL cover these directed scenarios:
- Exact value: sign 0, exp 0x7F, frac 0x400000, GRS 0, RNE -> result 0x3FC00000, fflags 0, valid_o 2 cycles later.
- Tie rounding, RNE, exp 0x80, G=1, R=S=0: frac 0x000001 -> 0x40000002 with NX; frac 0x000000 -> 0x40000000 with NX.
- Fraction carry: exp 0x7E, frac 0x7FFFFF, G=1, RNE -> 0x3F800000, fflags 5'b00001.
- Overflow, exp 0xFE, frac 0x7FFFFF, G=1: RNE -> 0x7F800000, fflags 5'b00101; exp_i 0xFF, RTZ -> 0x7F7FFFFF, 5'b00101; sign 1, RUP -> 0xFF7FFFFF.
- NaN: is_nan_i=1, nv_i=1 -> 0x7FC00000, fflags 5'b10000; is_inf_i=1, sign 1 -> 0xFF800000.
- Stall and flush: en=0 for 3 cycles holds outputs and uu_*; clear[0] with stage B valid -> valid_o=0, rd_o=0 next edge while stage A is kept.
